rr_grant_scheduler: RTL
=======================

// Module: rr_grant_scheduler
// PURPOSE
//   Round-robin scheduler sharing one 5-way select resource among 5 requesters.
//   Registers a 3-bit grant index for the 3-to-5 one-hot decoder, plus a one-hot copy.
//   Index 5 is the "no grant" code, so the decoder output is all zero when idle.
//   Bounds each grant with a release input and a hold-time limit.
// PARAMETERS
//   N_REQ     5   number of requesters (fixed at 5 to match decoder width)
//   IDX_W     3   grant index width
//   MAX_HOLD  8   max cycles one grant may be held before forced end (>=2)
// PORTS
//   clk            in   1      single clock, all logic on rising edge
//   reset          in   1      synchronous, active-high reset
//   req            in   5      request per requester, level-sensitive
//   release_in     in   1      current owner finished, ends grant this cycle
//   grant_idx      out  3      granted requester 0..4; 5 = none (to decoder bin_in)
//   grant_onehot   out  5      one-hot of grant_idx; 0 when none
//   grant_valid    out  1      1 while a grant is held
//   timeout_pulse  out  1      1-cycle pulse when a grant is ended by MAX_HOLD
// BEHAVIOUR
//   Reset (sync, active-high): state=IDLE, grant_idx=5, grant_onehot=0,
//     grant_valid=0, timeout_pulse=0, last=4, hold_cnt=0.
//     Because last=4, req[0] has first priority after reset.
//     Reset asserted mid-grant drops the grant at that edge and clears the pointer.
//   All outputs are registered. grant_idx is never 6 or 7.
//   FSM, 2 states:
//     IDLE:  outputs at idle values.
//            If req != 0, pick first set bit scanning last+1, last+2, ... (mod 5).
//            Next edge: grant_idx=g, grant_onehot=1<<g, grant_valid=1, hold_cnt=0 -> GRANT.
//            If req == 0, stay in IDLE.
//     GRANT: hold_cnt increments each cycle.
//            Grant ends at the edge where any of these holds:
//              (a) release_in=1;
//              (b) req[g]=0;
//              (c) hold_cnt==MAX_HOLD-1, i.e. MAX_HOLD cycles held.
//            On end: -> IDLE, last=g, outputs to idle values at that edge.
//            timeout_pulse=1 for that one cycle only if (c) holds and (a) and (b) do not.
//   Latency: req to grant_valid is 1 cycle from IDLE.
//     Between consecutive grants there is always exactly 1 idle cycle (grant_idx=5).
//   Requests on non-granted lines during GRANT are ignored, not queued.
//     They are re-evaluated in IDLE.
//   Sole requester re-wins after its gap. Round-robin guarantees no starvation:
//     any held req is granted within 5 grant slots.
//   release_in in IDLE is ignored. hold_cnt saturates; it never wraps inside a grant.
// TESTING
//   reset, then req=5'b00001 -> 1 cycle later grant_idx=0, onehot=00001, valid=1.
//   req=5'b11111 held, release_in pulsed each grant -> grant order 0,1,2,3,4,0.
//     1 idle cycle with grant_idx=5 between each grant.
//   req=5'b00100 held, no release -> valid high 8 cycles, timeout_pulse at end.
//     Then idle 1 cycle, then re-granted idx 2.
//   grant to 3, release_in=1 and hold limit same cycle -> grant ends, timeout_pulse=0.
//   grant to 1, req[1] drops, req[4] rises -> next edge idle, then grant_idx=4.
//   reset asserted during grant to 2 -> next edge idx=5, valid=0.
//     Then req=5'b11111 -> idx 0.

Source files
------------

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler for one 5-way select resource shared by 5 requesters.
// Drives a registered grant index (5 = none) and its one-hot copy; each grant is bounded by release or hold limit.
module rr_grant_scheduler #(
  parameter int unsigned N_REQ    = 5,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             release_in,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             grant_valid,
  output logic             timeout_pulse
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;

  localparam logic [IDX_W-1:0] IDX_NONE  = IDX_W'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [N_REQ-1:0] grant_onehot_q, grant_onehot_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [IDX_W-1:0] pick_idx_c;
  logic             pick_found_c;
  logic             owner_req_c;
  logic             hit_limit_c;
  logic             end_grant_c;

  // Scan last+1, last+2, ... last+N_REQ (mod N_REQ); the final slot lets a sole requester re-win.
  always_comb begin
    logic [SUM_W-1:0] cand;
    pick_idx_c   = IDX_NONE;
    pick_found_c = 1'b0;
    for (int off = 1; off <= int'(N_REQ); off++) begin
      cand = SUM_W'(last_q) + SUM_W'(off);
      if (cand >= SUM_W'(N_REQ)) begin
        cand = cand - SUM_W'(N_REQ);
      end
      if (!pick_found_c && req[cand[IDX_W-1:0]]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand[IDX_W-1:0];
      end
    end
  end

  assign owner_req_c = |(req & grant_onehot_q);
  assign hit_limit_c = (hold_cnt_q == HOLD_LAST);
  assign end_grant_c = release_in || !owner_req_c || hit_limit_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    grant_idx_d     = grant_idx_q;
    grant_onehot_d  = grant_onehot_q;
    grant_valid_d   = grant_valid_q;
    timeout_pulse_d = 1'b0;
    last_d          = last_q;
    hold_cnt_d      = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        grant_idx_d    = IDX_NONE;
        grant_onehot_d = '0;
        grant_valid_d  = 1'b0;
        hold_cnt_d     = '0;
        if (pick_found_c) begin
          state_d        = ST_GRANT;
          grant_idx_d    = pick_idx_c;
          grant_onehot_d = N_REQ'(1) << pick_idx_c;
          grant_valid_d  = 1'b1;
        end
      end

      ST_GRANT: begin
        if (end_grant_c) begin
          state_d         = ST_IDLE;
          last_d          = grant_idx_q;
          grant_idx_d     = IDX_NONE;
          grant_onehot_d  = '0;
          grant_valid_d   = 1'b0;
          hold_cnt_d      = '0;
          // Pulse only when the hold limit alone ended the grant.
          timeout_pulse_d = hit_limit_c && !release_in && owner_req_c;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d        = ST_IDLE;
        grant_idx_d    = IDX_NONE;
        grant_onehot_d = '0;
        grant_valid_d  = 1'b0;
        hold_cnt_d     = '0;
      end
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      grant_idx_q     <= IDX_NONE;
      grant_onehot_q  <= '0;
      grant_valid_q   <= 1'b0;
      timeout_pulse_q <= 1'b0;
      last_q          <= LAST_RST;
      hold_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      grant_idx_q     <= grant_idx_d;
      grant_onehot_q  <= grant_onehot_d;
      grant_valid_q   <= grant_valid_d;
      timeout_pulse_q <= timeout_pulse_d;
      last_q          <= last_d;
      hold_cnt_q      <= hold_cnt_d;
    end
  end

  assign grant_idx     = grant_idx_q;
  assign grant_onehot  = grant_onehot_q;
  assign grant_valid   = grant_valid_q;
  assign timeout_pulse = timeout_pulse_q;

  // Structural invariants of the registered outputs.
  a_idx_range: assert property (@(posedge clk) disable iff (reset)
    grant_idx_q <= IDX_NONE);
  a_valid_idx: assert property (@(posedge clk) disable iff (reset)
    grant_valid_q == (grant_idx_q != IDX_NONE));
  a_onehot: assert property (@(posedge clk) disable iff (reset)
    grant_valid_q ? $onehot(grant_onehot_q) : (grant_onehot_q == '0));

endmodule
